// File: rtl/pc_fetch.sv
// pc_fetch: owns the PC, fetches from instruction memory and fills the IF/ID register,
// with delay-slot redirects, a one-entry stall hold buffer and misaligned-fetch bubbles.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        if_id_exc_adel
);
  typedef enum logic [1:0] {FETCH, HOLD, ERR} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, pend_pc_q, pend_pc_d, hold_pc_q, hold_pc_d, hold_instr_q, hold_instr_d;
  logic [31:0] if_id_pc_q, if_id_pc_d, if_id_instr_q, if_id_instr_d, ld_pc, ld_instr, tgt;
  logic        pend_valid_q, pend_valid_d, if_id_valid_q, if_id_valid_d, if_id_exc_q, if_id_exc_d;
  logic        ld, ld_exc;
  assign imem_req       = state_q == FETCH && pc_q[1:0] == 2'b00;
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_valid    = if_id_valid_q;
  assign if_id_exc_adel = if_id_exc_q;
  assign tgt = redirect ? next_pc : pend_valid_q ? pend_pc_q : pc_q + 32'd4;
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    pend_valid_d  = pend_valid_q;
    hold_pc_d     = hold_pc_q;
    hold_instr_d  = hold_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_exc_d   = if_id_exc_q;
    ld            = 1'b0;
    ld_pc         = pc_q;
    ld_instr      = imem_rdata;
    ld_exc        = 1'b0;
    case (state_q)
      FETCH: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = ERR;
          if (redirect) begin
            pend_pc_d    = next_pc;
            pend_valid_d = 1'b1;
          end
        end else if (imem_ready) begin
          pc_d         = tgt;
          pend_valid_d = 1'b0;
          if (stall && !flush) begin
            hold_pc_d    = pc_q;
            hold_instr_d = imem_rdata;
            state_d      = HOLD;
          end else begin
            ld = 1'b1;
          end
        end else if (redirect) begin
          // the outstanding request is the delay slot; the target waits for it
          pend_pc_d    = next_pc;
          pend_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) pc_d = next_pc;
        if (flush || !stall) state_d = FETCH;
        ld       = !stall;
        ld_pc    = hold_pc_q;
        ld_instr = hold_instr_q;
      end
      ERR: begin
        ld       = !stall;
        ld_instr = NOP_WORD;
        ld_exc   = 1'b1;
        if (redirect) begin
          pc_d         = next_pc;
          pend_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    if (flush) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_WORD;
      if_id_exc_d   = 1'b0;
    end else if (ld) begin
      if_id_valid_d = 1'b1;
      if_id_pc_d    = ld_pc;
      if_id_instr_d = ld_instr;
      if_id_exc_d   = ld_exc;
    end else if (!stall) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_WORD;
      if_id_exc_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      pend_pc_q     <= '0;
      pend_valid_q  <= 1'b0;
      hold_pc_q     <= '0;
      hold_instr_q  <= '0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_WORD;
      if_id_valid_q <= 1'b0;
      if_id_exc_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      pend_valid_q  <= pend_valid_d;
      hold_pc_q     <= hold_pc_d;
      hold_instr_q  <= hold_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_exc_q   <= if_id_exc_d;
    end
  end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed scenarios plus randomized stall/flush/redirect/wait traffic,
// every cycle compared against a behavioural fetch model.
module tb_pc_fetch;
  logic        clk = 1'b0, reset, stall, flush, redirect, imem_ready;
  logic [31:0] next_pc, imem_rdata;
  logic        imem_req, if_id_valid, if_id_exc_adel;
  logic [31:0] imem_addr, pc, if_id_pc, if_id_instr;
  int n_chk = 0, n_bad = 0;
  logic [31:0] m_pc, m_pp, m_ipc, m_ins;
  logic        m_pv, m_err, m_v, m_exc;
  logic [63:0] hq[$];
  pc_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect(redirect),
    .next_pc(next_pc), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc(pc), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .if_id_exc_adel(if_id_exc_adel)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction
  function automatic logic m_req();
    return !m_err && hq.size() == 0 && m_pc[1:0] == 2'b00;
  endfunction
  task automatic m_reset();
    m_pc = 32'h0000_3000; m_pp = '0; m_pv = 0; m_err = 0;
    m_ipc = '0; m_ins = '0; m_v = 0; m_exc = 0;
    hq.delete();
  endtask
  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_req", 32'(imem_req), 32'(m_req()));
    chk("if_id_valid", 32'(if_id_valid), 32'(m_v));
    chk("if_id_exc", 32'(if_id_exc_adel), 32'(m_exc));
    chk("if_id_instr", if_id_instr, m_ins);
    chk("if_id_pc", if_id_pc, m_ipc);
  endtask
  task automatic step(input logic st, input logic fl, input logic rd, input logic [31:0] np, input logic rdy);
    logic [31:0] opc, tgt, lpc, lins;
    logic ld, lexc;
    opc = m_pc; ld = 0; lexc = 0; lpc = opc; lins = 32'h0;
    tgt = rd ? np : m_pv ? m_pp : opc + 32'd4;
    if (m_err) begin
      ld = !st; lexc = 1;
      if (rd) begin m_pc = np; m_err = 0; m_pv = 0; end
    end else if (hq.size() != 0) begin
      if (rd) m_pc = np;
      if (!st || fl) begin
        lpc = hq[0][63:32]; lins = hq[0][31:0]; ld = !st;
        hq.delete();
      end
    end else if (opc[1:0] != 2'b00) begin
      m_err = 1;
      if (rd) begin m_pp = np; m_pv = 1; end
    end else if (rdy) begin
      m_pc = tgt; m_pv = 0; lins = mem(opc);
      if (st && !fl) hq.push_back({opc, lins});
      else ld = 1;
    end else if (rd) begin
      m_pp = np; m_pv = 1;
    end
    if (fl) begin m_v = 0; m_ins = 0; m_exc = 0; end
    else if (ld) begin m_v = 1; m_ipc = lpc; m_ins = lins; m_exc = lexc; end
    else if (!st) begin m_v = 0; m_ins = 0; m_exc = 0; end
  endtask
  task automatic cyc(input logic st, input logic fl, input logic rd, input logic [31:0] np, input logic rdy);
    @(negedge clk);
    check_all();
    stall = st; flush = fl; redirect = rd; next_pc = np; imem_ready = rdy; imem_rdata = mem(m_pc);
    @(posedge clk);
    #1 step(st, fl, rd, np, rdy);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1; stall = 0; flush = 0; redirect = 0; next_pc = 0; imem_ready = 0; imem_rdata = 0;
    m_reset();
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    logic st, fl, rd, rdy;
    logic [31:0] np;
    do_reset();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_valid", 32'(if_id_valid), 0);
    chk("rst_req", 32'(imem_req), 1);
    cyc(0, 0, 0, 0, 1);
    chk("zw_pc1", pc, 32'h3004);
    chk("zw_ifpc1", if_id_pc, 32'h3000);
    chk("zw_valid1", 32'(if_id_valid), 1);
    cyc(0, 0, 0, 0, 1);
    chk("zw_pc2", pc, 32'h3008);
    chk("zw_ifpc2", if_id_pc, 32'h3004);
    cyc(0, 0, 1, 32'h3100, 0);
    cyc(0, 0, 0, 0, 0);
    chk("ds_pc_wait", pc, 32'h3008);
    cyc(0, 0, 0, 0, 1);
    chk("ds_ifpc", if_id_pc, 32'h3008);
    chk("ds_instr", if_id_instr, mem(32'h3008));
    chk("ds_target", imem_addr, 32'h3100);
    do_reset();
    repeat (4) cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("st_hold_ifpc", if_id_pc, 32'h300C);
    chk("st_hold_req", 32'(imem_req), 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("st_hold_ifpc3", if_id_pc, 32'h300C);
    cyc(0, 0, 0, 0, 0);
    chk("st_rel_ifpc", if_id_pc, 32'h3010);
    chk("st_rel_addr", imem_addr, 32'h3014);
    cyc(0, 0, 0, 0, 1);
    chk("st_next_ifpc", if_id_pc, 32'h3014);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0);
    chk("fl_valid", 32'(if_id_valid), 0);
    chk("fl_instr", if_id_instr, 32'h0);
    chk("fl_pc", pc, 32'h301C);
    chk("fl_req", 32'(imem_req), 1);
    cyc(0, 0, 0, 0, 1);
    chk("fl_discard", if_id_pc, 32'h301C);
    cyc(0, 0, 1, 32'h3102, 1);
    chk("mis_req", 32'(imem_req), 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("mis_exc", 32'(if_id_exc_adel), 1);
    chk("mis_ifpc", if_id_pc, 32'h3102);
    cyc(0, 0, 1, 32'h3200, 0);
    chk("mis_resume", imem_addr, 32'h3200);
    cyc(0, 0, 0, 0, 1);
    chk("mis_clear", 32'(if_id_exc_adel), 0);
    chk("mis_ifpc2", if_id_pc, 32'h3200);
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1);
    cyc(0, 0, 0, 0, 1);
    chk("wrap", pc, 32'h0);
    cyc(0, 0, 0, 0, 0);
    #2 reset = 1;
    #1;
    chk("async_pc", pc, 32'h3000);
    chk("async_valid", 32'(if_id_valid), 0);
    chk("async_instr", if_id_instr, 32'h0);
    chk("async_ifpc", if_id_pc, 32'h0);
    m_reset();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 600; i++) begin
      st  = ($urandom % 5) == 0;
      fl  = ($urandom % 20) == 0;
      rd  = ($urandom % 7) == 0;
      rdy = ($urandom % 3) != 0;
      np  = $urandom & 32'h0000_FFFC;
      if (($urandom % 16) == 0) np = np | 32'h2;
      if (($urandom % 32) == 0) np = 32'hFFFF_FFF8;
      cyc(st, fl, rd, np, rdy);
    end
    @(negedge clk);
    check_all();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
